// File: rtl/ring_router_mux.sv
// ring_router_mux: per-worm arbiter merging ring through-traffic and local
// injection onto the outgoing ring link. Define RING_ROUTER_MUX_REG_EN for a registered output.
package ring_router_mux_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit_t;
endpackage

module ring_router_mux
    import ring_router_mux_pkg::*;
#(
    parameter int PRIO_RING = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  dii_flit_t in_ring,
    output logic      in_ring_ready,
    input  dii_flit_t in_local,
    output logic      in_local_ready,
    output dii_flit_t out_ring,
    input  logic      out_ring_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RING,
        S_LOCAL
    } state_t;

    state_t    state_q, state_d;
    logic      last_local_q, last_local_d;
    logic      gnt_ring, gnt_local;
    logic      arb_ready;
    logic      accept;
    dii_flit_t arb;

    // Grant: decided live in IDLE, held by the worm owner otherwise.
    always_comb begin
        gnt_ring  = 1'b0;
        gnt_local = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_ring.valid && in_local.valid) begin
                    if (PRIO_RING != 0 || last_local_q) gnt_ring = 1'b1;
                    else gnt_local = 1'b1;
                end else begin
                    gnt_ring  = in_ring.valid;
                    gnt_local = in_local.valid;
                end
            end
            S_RING:  gnt_ring  = 1'b1;
            S_LOCAL: gnt_local = 1'b1;
            default: ;
        endcase
    end

    // Select the granted source's flit.
    always_comb begin
        arb = '0;
        if (gnt_ring) arb = in_ring;
        else if (gnt_local) arb = in_local;
    end

    assign in_ring_ready  = gnt_ring & arb_ready & ~rst;
    assign in_local_ready = gnt_local & arb_ready & ~rst;
    assign accept         = arb.valid & arb_ready & ~rst;

    // Worm tracking: lock on a first flit, release on an accepted last flit.
    always_comb begin
        state_d      = state_q;
        last_local_d = last_local_q;
        if (accept) begin
            if (state_q == S_IDLE) last_local_d = gnt_local;
            if (arb.last) state_d = S_IDLE;
            else if (state_q == S_IDLE) state_d = gnt_local ? S_LOCAL : S_RING;
        end
    end

    // State and fairness flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_local_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_local_q <= last_local_d;
        end
    end

`ifdef RING_ROUTER_MUX_REG_EN
    dii_flit_t ent0_q, ent0_d;
    dii_flit_t ent1_q, ent1_d;
    logic      pop;

    // Accept only while a slot is free; keeps out_ring_ready off the input path.
    assign arb_ready = ~(ent0_q.valid & ent1_q.valid);
    assign out_ring  = ent0_q;

    // Two-entry skid buffer: ent0 is the head, shift on pop, fill first free slot.
    always_comb begin
        pop    = ent0_q.valid & out_ring_ready;
        ent0_d = pop ? ent1_q : ent0_q;
        ent1_d = pop ? '0 : ent1_q;
        if (accept) begin
            if (!ent0_d.valid) ent0_d = arb;
            else ent1_d = arb;
        end
    end

    // Skid buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end
`else
    assign arb_ready = out_ring_ready;

    // Zero-latency pass-through of the granted flit.
    always_comb begin
        out_ring       = arb;
        out_ring.valid = arb.valid & ~rst;
    end
`endif

endmodule
